// File: rtl/pmem_pkg.sv
// Shared constants and types for the physical-memory arbiter and its burst adapter.
package pmem_pkg;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned BEATS  = LINE_W / BEAT_W;
    localparam int unsigned OFFS_W = 5;
    localparam int unsigned CNT_W  = $clog2(BEATS);

    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFS_W) - 32'd1);

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StWrB,
        StDone
    } arb_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_id_t;

endpackage

// File: rtl/line_burst_adapter.sv
// Splits a cacheline into BEATS memory beats: beat counter, read-line assembly and
// write-beat mux. The arbiter FSM drives start/active and consumes last_beat.
module line_burst_adapter
    import pmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              active,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] wdata,
    input  logic [BEAT_W-1:0] burst_i,
    output logic              last_beat,
    output logic [LINE_W-1:0] line,
    output logic [BEAT_W-1:0] burst_o
);

    logic [CNT_W-1:0]  cnt_q;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] wdata_q;
    logic              beat;

    assign beat      = active && mem_resp;
    assign last_beat = beat && (cnt_q == CNT_W'(BEATS - 1));
    assign burst_o   = wdata_q[cnt_q*BEAT_W +: BEAT_W];

    // Line with the beat currently on the bus merged in, so the arbiter can
    // capture the complete line on the same edge that accepts the last beat.
    always_comb begin
        line = line_q;
        line[cnt_q*BEAT_W +: BEAT_W] = burst_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            line_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            cnt_q   <= '0;
            line_q  <= '0;
            wdata_q <= wdata;
        end else if (beat) begin
            cnt_q  <= cnt_q + 1'b1;
            line_q <= line;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter of icache (A) and dcache (B) line requests onto one burst
// memory port; returns the assembled line with a one-cycle resp pulse.
module pmem_arbiter
    import pmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read_a,
    input  logic [31:0]       pmem_addr_a,
    output logic [LINE_W-1:0] pmem_rdata_a,
    output logic              pmem_resp_a,
    input  logic              pmem_read_b,
    input  logic              pmem_write_b,
    input  logic [31:0]       pmem_addr_b,
    input  logic [LINE_W-1:0] pmem_wdata_b,
    output logic [LINE_W-1:0] pmem_rdata_b,
    output logic              pmem_resp_b,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [BEAT_W-1:0] burst_o,
    input  logic [BEAT_W-1:0] burst_i,
    input  logic              mem_resp
);

    arb_state_t        state_q, state_d;
    port_id_t          last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              resp_a_q, resp_a_d;
    logic              resp_b_q, resp_b_d;
    logic [31:0]       addr_q, sel_addr;
    logic [LINE_W-1:0] rdata_a_q, rdata_b_q, line;
    logic              start, grant_b, in_burst, last_beat;

    assign in_burst = (state_q == StRdA) || (state_q == StRdB) || (state_q == StWrB);
    assign sel_addr = grant_b ? pmem_addr_b : pmem_addr_a;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        resp_a_d     = 1'b0;
        resp_b_d     = 1'b0;
        start        = 1'b0;
        grant_b      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pmem_read_a && (pmem_read_b || pmem_write_b)) begin
                    start   = 1'b1;
                    grant_b = (last_grant_q == PORT_A);
                end else if (pmem_read_a) begin
                    start = 1'b1;
                end else if (pmem_read_b || pmem_write_b) begin
                    start   = 1'b1;
                    grant_b = 1'b1;
                end
                if (start) begin
                    last_grant_d = grant_b ? PORT_B : PORT_A;
                    // A simultaneous read+write on B is served as a write.
                    if (grant_b && pmem_write_b) begin
                        state_d     = StWrB;
                        mem_write_d = 1'b1;
                    end else begin
                        state_d    = grant_b ? StRdB : StRdA;
                        mem_read_d = 1'b1;
                    end
                end
            end
            StRdA, StRdB, StWrB: begin
                if (last_beat) begin
                    state_d     = StDone;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    resp_a_d    = (state_q == StRdA);
                    resp_b_d    = (state_q != StRdA);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= PORT_B;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_a_q     <= 1'b0;
            resp_b_q     <= 1'b0;
            addr_q       <= '0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            resp_a_q     <= resp_a_d;
            resp_b_q     <= resp_b_d;
            if (start) begin
                addr_q <= sel_addr & ADDR_MASK;
            end
            if (last_beat && (state_q == StRdA)) begin
                rdata_a_q <= line;
            end
            if (last_beat && (state_q == StRdB)) begin
                rdata_b_q <= line;
            end
        end
    end

    line_burst_adapter u_adapter (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .active    (in_burst),
        .mem_resp  (mem_resp),
        .wdata     (pmem_wdata_b),
        .burst_i   (burst_i),
        .last_beat (last_beat),
        .line      (line),
        .burst_o   (burst_o)
    );

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_address  = addr_q;
    assign pmem_resp_a  = resp_a_q;
    assign pmem_resp_b  = resp_b_q;
    assign pmem_rdata_a = rdata_a_q;
    assign pmem_rdata_b = rdata_b_q;

    b_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(pmem_read_b && pmem_write_b));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pmem_read_a = 1'b0;
    logic [31:0]  pmem_addr_a = '0;
    logic [255:0] pmem_rdata_a;
    logic         pmem_resp_a;
    logic         pmem_read_b = 1'b0;
    logic         pmem_write_b = 1'b0;
    logic [31:0]  pmem_addr_b = '0;
    logic [255:0] pmem_wdata_b = '0;
    logic [255:0] pmem_rdata_b;
    logic         pmem_resp_b;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         mem_resp;

    pmem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read_a  (pmem_read_a),
        .pmem_addr_a  (pmem_addr_a),
        .pmem_rdata_a (pmem_rdata_a),
        .pmem_resp_a  (pmem_resp_a),
        .pmem_read_b  (pmem_read_b),
        .pmem_write_b (pmem_write_b),
        .pmem_addr_b  (pmem_addr_b),
        .pmem_wdata_b (pmem_wdata_b),
        .pmem_rdata_b (pmem_rdata_b),
        .pmem_resp_b  (pmem_resp_b),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .burst_o      (burst_o),
        .burst_i      (burst_i),
        .mem_resp     (mem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Memory: zero-wait answers in the same cycle mem_read/mem_write is seen;
    // gap_mode inserts 3 idle cycles after every accepted beat.
    logic [63:0]  mem_data [4];
    logic [1:0]   beat_idx = '0;
    logic         mem_en = 1'b1;
    bit           gap_mode = 1'b0;
    int           gap_cnt = 0;
    int           n_beats = 0;
    int           wr_hi = 0;
    logic [63:0]  wq[$];

    assign mem_resp = (mem_read | mem_write) & mem_en;
    assign burst_i  = mem_data[beat_idx];

    initial begin
        bit fired, busy;
        forever begin
            @(posedge clk);
            fired = mem_resp;
            busy  = mem_read | mem_write;
            if (fired) n_beats++;
            if (mem_write) wr_hi++;
            if (fired && mem_write) wq.push_back(burst_o);
            #1;
            if (!busy) beat_idx = 2'd0;
            else if (fired) beat_idx = beat_idx + 2'd1;
            if (fired && gap_mode) gap_cnt = 3;
            else if (gap_cnt > 0) gap_cnt--;
            mem_en = (gap_cnt == 0);
        end
    end

    // Reference model: one transaction at a time, tracked as phase/beat count.
    bit           model_on = 1'b0;
    int           m_phase = 0;       // 0 waiting, 1 transferring, 2 responding
    bit           m_port_b = 1'b0;
    bit           m_wr = 1'b0;
    bit           m_last_b = 1'b1;
    int           m_beats = 0;
    logic [31:0]  m_addr = '0;
    logic [255:0] m_wdata = '0;
    logic [255:0] m_line = '0;
    logic         e_read = 1'b0, e_write = 1'b0, e_resp_a = 1'b0, e_resp_b = 1'b0;
    logic [255:0] e_rdata_a = '0, e_rdata_b = '0;
    bit           hold_a = 1'b1, hold_b = 1'b1;

    task automatic compare_outputs();
        chk("mem_read", 256'(mem_read), 256'(e_read));
        chk("mem_write", 256'(mem_write), 256'(e_write));
        chk("resp_a", 256'(pmem_resp_a), 256'(e_resp_a));
        chk("resp_b", 256'(pmem_resp_b), 256'(e_resp_b));
        if (e_read || e_write) chk("mem_address", 256'(mem_address), 256'(m_addr));
        if (e_write) chk("burst_o", 256'(burst_o), 256'(m_wdata[m_beats*64 +: 64]));
        if (hold_a || e_resp_a) chk("rdata_a", pmem_rdata_a, e_rdata_a);
        if (hold_b || e_resp_b) chk("rdata_b", pmem_rdata_b, e_rdata_b);
    endtask

    task automatic model_step();
        bit ra, rb;
        if (rst) begin
            m_phase = 0; m_beats = 0; m_last_b = 1'b1;
            e_read = 1'b0; e_write = 1'b0; e_resp_a = 1'b0; e_resp_b = 1'b0;
            e_rdata_a = '0; e_rdata_b = '0; hold_a = 1'b1; hold_b = 1'b1;
        end else if (m_phase == 0) begin
            ra = pmem_read_a;
            rb = pmem_read_b | pmem_write_b;
            if (ra || rb) begin
                m_port_b = (ra && rb) ? !m_last_b : rb;
                m_last_b = m_port_b;
                m_wr     = m_port_b && pmem_write_b;
                m_addr   = m_port_b ? pmem_addr_b : pmem_addr_a;
                m_addr   = m_addr - (m_addr % 32);
                m_wdata  = pmem_wdata_b;
                m_beats  = 0;
                m_line   = '0;
                if (!m_wr && !m_port_b) hold_a = 1'b0;
                if (!m_wr && m_port_b) hold_b = 1'b0;
                e_read  = !m_wr;
                e_write = m_wr;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (mem_resp) begin
                if (!m_wr) m_line[m_beats*64 +: 64] = burst_i;
                m_beats++;
                if (m_beats == 4) begin
                    m_phase = 2;
                    e_read = 1'b0;
                    e_write = 1'b0;
                    e_resp_a = !m_port_b;
                    e_resp_b = m_port_b;
                    if (!m_wr && !m_port_b) begin e_rdata_a = m_line; hold_a = 1'b1; end
                    if (!m_wr && m_port_b) begin e_rdata_b = m_line; hold_b = 1'b1; end
                end
            end
        end else begin
            e_resp_a = 1'b0;
            e_resp_b = 1'b0;
            m_phase = 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                compare_outputs();
                model_step();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits for either resp; took = edges until it is visible.
    task automatic wait_any(input int limit, output bit got_b, output int took);
        took = 0;
        do begin
            tick();
            took++;
        end while (!pmem_resp_a && !pmem_resp_b && took < limit);
        got_b = pmem_resp_b;
        if (!pmem_resp_a && !pmem_resp_b) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: no resp after %0d cycles, required within %0d", took, limit);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit gb, stable;
        int took, cnt;
        logic [255:0] exp_line, line1;

        mem_data = '{64'h1, 64'h2, 64'h3, 64'h4};
        @(posedge clk);
        model_on = 1'b1;
        do_reset();

        // Reset state.
        chk("rst_mem_read", 256'(mem_read), 256'(0));
        chk("rst_mem_write", 256'(mem_write), 256'(0));
        chk("rst_mem_address", 256'(mem_address), 256'(0));
        chk("rst_burst_o", 256'(burst_o), 256'(0));
        chk("rst_resp", 256'({pmem_resp_a, pmem_resp_b}), 256'(0));
        chk("rst_rdata_a", pmem_rdata_a, 256'(0));

        // Read A only: request cycle counts as cycle 1, resp lands in cycle 6.
        pmem_addr_a = 32'h0000_1234;
        pmem_read_a = 1'b1;
        tick();
        chk("t1_mem_read", 256'(mem_read), 256'(1));
        chk("t1_mem_address", 256'(mem_address), 256'(32'h0000_1220));
        wait_any(20, gb, took);
        chk("t1_latency", 256'(took), 256'(4));
        chk("t1_port", 256'(gb), 256'(0));
        exp_line = {64'h4, 64'h3, 64'h2, 64'h1};
        chk("t1_rdata_a", pmem_rdata_a, exp_line);
        pmem_read_a = 1'b0;
        tick();
        chk("t1_resp_a_pulse", 256'(pmem_resp_a), 256'(0));

        // Write B: beats leave in order A,B,C,D; mem_write high for exactly 4 cycles.
        wq.delete();
        wr_hi = 0;
        pmem_wdata_b = {64'hD, 64'hC, 64'hB, 64'hA};
        pmem_addr_b  = 32'h0000_2468;
        pmem_write_b = 1'b1;
        wait_any(20, gb, took);
        pmem_write_b = 1'b0;
        chk("t2_latency", 256'(took), 256'(5));
        chk("t2_port", 256'(gb), 256'(1));
        chk("t2_mem_write_after", 256'(mem_write), 256'(0));
        chk("t2_beats", 256'(wq.size()), 256'(4));
        for (int k = 0; k < wq.size(); k++) chk("t2_burst_o_seq", 256'(wq[k]), 256'(64'hA + k));
        chk("t2_write_cycles", 256'(wr_hi), 256'(4));
        tick();

        // Simultaneous A read and B write after reset: A first, twice.
        do_reset();
        for (int pair = 0; pair < 2; pair++) begin
            pmem_addr_a  = 32'h0000_0100;
            pmem_addr_b  = 32'h0000_0200;
            pmem_wdata_b = {64'h44, 64'h33, 64'h22, 64'h11};
            pmem_read_a  = 1'b1;
            pmem_write_b = 1'b1;
            wait_any(20, gb, took);
            chk("t3_first_is_a", 256'(gb), 256'(0));
            chk("t3_first_latency", 256'(took), 256'(5));
            pmem_read_a = 1'b0;
            wait_any(20, gb, took);
            chk("t3_second_is_b", 256'(gb), 256'(1));
            chk("t3_second_latency", 256'(took), 256'(6));
            pmem_write_b = 1'b0;
            tick();
        end

        // 3-cycle gaps between beats: beats at edges 2, 6, 10, 14.
        mem_data = '{64'h11, 64'h22, 64'h33, 64'h44};
        gap_mode = 1'b1;
        n_beats = 0;
        pmem_addr_a = 32'h0000_0040;
        pmem_read_a = 1'b1;
        wait_any(40, gb, took);
        pmem_read_a = 1'b0;
        chk("t4_latency", 256'(took), 256'(14));
        chk("t4_beats_at_resp", 256'(n_beats), 256'(4));
        exp_line = {64'h44, 64'h33, 64'h22, 64'h11};
        chk("t4_rdata_a", pmem_rdata_a, exp_line);
        gap_mode = 1'b0;
        repeat (4) tick();

        // Reset during beat 2 of a B read.
        mem_data = '{64'h51, 64'h52, 64'h53, 64'h54};
        pmem_addr_b = 32'h0000_0300;
        pmem_read_b = 1'b1;
        repeat (3) tick();
        chk("t5_in_burst", 256'(mem_read), 256'(1));
        rst = 1'b1;
        pmem_read_b = 1'b0;
        tick();
        chk("t5_mem_read_cleared", 256'(mem_read), 256'(0));
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            tick();
            if (pmem_resp_b) cnt++;
        end
        chk("t5_no_resp_b", 256'(cnt), 256'(0));
        mem_data = '{64'h5, 64'h6, 64'h7, 64'h8};
        pmem_addr_a = 32'h0000_0500;
        pmem_read_a = 1'b1;
        wait_any(20, gb, took);
        pmem_read_a = 1'b0;
        chk("t5_a_latency", 256'(took), 256'(5));
        chk("t5_a_port", 256'(gb), 256'(0));
        exp_line = {64'h8, 64'h7, 64'h6, 64'h5};
        chk("t5_rdata_a", pmem_rdata_a, exp_line);
        tick();

        // Back-to-back B reads: resp spacing 6, rdata_b stable in between.
        mem_data = '{64'h61, 64'h62, 64'h63, 64'h64};
        pmem_addr_b = 32'h0000_0700;
        pmem_read_b = 1'b1;
        wait_any(20, gb, took);
        chk("t6_first_latency", 256'(took), 256'(5));
        line1 = {64'h64, 64'h63, 64'h62, 64'h61};
        chk("t6_first_rdata_b", pmem_rdata_b, line1);
        mem_data = '{64'h71, 64'h72, 64'h73, 64'h74};
        stable = 1'b1;
        took = 0;
        do begin
            tick();
            took++;
            if (!pmem_resp_b && pmem_rdata_b !== line1) stable = 1'b0;
        end while (!pmem_resp_b && took < 20);
        pmem_read_b = 1'b0;
        chk("t6_spacing", 256'(took), 256'(6));
        chk("t6_rdata_hold", 256'(stable), 256'(1));
        exp_line = {64'h74, 64'h73, 64'h72, 64'h71};
        chk("t6_second_rdata_b", pmem_rdata_b, exp_line);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
